seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Parametrised multi-cycle adder: WIDTH-bit operands are summed CHUNK bits per clock through a single CHUNK-bit ripple slice, with the carry registered between slices. It is the area-reduced successor to the 32-bit combinational ripple-carry adder. It sits in the datapath behind a valid/ready handshake on both input and output, and trades latency for a narrow carry chain and a short critical path.

## Interface
- WIDTH, 32: operand and sum width; must be an integer multiple of CHUNK.
- CHUNK, 8: bits added per cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and c_in present.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- c_in  input  1  carry into bit 0.
- sub  input  1  subtract mode; present only with ADDSUB_EN.
- out_valid  output  1  sum/c_out valid.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN, DONE. Registered state: op_a, op_b, carry, idx (clog2(NCHUNK) bits, minimum 1), sum, c_out.
- IDLE: in_ready=1. When in_valid is high, latch a into op_a and b into op_b. Set carry=c_in and idx=0, then go to RUN.
- RUN: each cycle compute {cy, s} = op_a[idx*CHUNK +: CHUNK] + op_b[same] + carry.
  - Write s into sum[idx*CHUNK +: CHUNK] and set carry=cy.
  - When idx==NCHUNK-1, set c_out=cy and go to DONE. Otherwise idx++.
- DONE: out_valid=1. sum and c_out are held stable. When out_ready is high, go to IDLE; out_valid drops on the next edge.
- Results are modulo 2^WIDTH; c_out is the true unsigned carry.
- Input changes after acceptance have no effect.
- in_valid during RUN or DONE is ignored because in_ready=0. A new operation is accepted only from IDLE.
- sum is undefined-but-deterministic during RUN: it holds partial slices. Consumers must qualify sum with out_valid.
- Reset (rst_n low, at any time including mid-RUN or in DONE):
  - state=IDLE, idx=0, carry=0.
  - sum=0, c_out=0, out_valid=0, busy=0, in_ready=1.
  - Any in-flight operation is discarded with no output.

## Timing
- Acceptance edge T0 is the edge where in_valid && in_ready.
- Slice k is written at edge T0+1+k. out_valid rises after edge T0+NCHUNK. Latency is NCHUNK cycles; WIDTH=32, CHUNK=8 gives 4.
- NCHUNK=1 (CHUNK==WIDTH): a single RUN cycle, latency 1.
- Result handshake completes at the edge with out_valid && out_ready. in_ready rises the following cycle.
- Minimum issue interval is NCHUNK+2 cycles with out_ready held high.
- in_ready, busy and out_valid are decoded from registered state only; there is no combinational input-to-output path.

## Configuration
- ADDSUB_EN defined:
  - The sub port exists. On acceptance with sub=1, the block latches op_b=~b and carry=1, ignoring c_in.
  - The result is a-b mod 2^WIDTH. c_out=1 means no borrow (a>=b).
  - With sub=0 behaviour is identical to add.
- ADDSUB_EN undefined: no sub port; add only.

## Structure
- Package adder_pkg holds the state typedef (IDLE, RUN, DONE) and a function nchunk(WIDTH, CHUNK).
- One sub-module, adder_chunk: combinational CHUNK-bit ripple adder with ports a, b, c_in, sum, c_out. It is instantiated once and fed by an idx-selected slice mux.
- Elaboration-time check: WIDTH % CHUNK == 0.

## Test plan
- Basic add: a=1024, b=4096, c_in=0 -> sum=5120, c_out=0. out_valid rises exactly 4 cycles after acceptance.
- Multi-slice add: a=34343434, b=8123659 -> sum=42467093, c_out=0.
- Full carry: a=0xFFFFFFFF, b=0xFFFFFFFF -> sum=0xFFFFFFFE, c_out=1. Also a=0xFFFFFFFF, b=0, c_in=1 -> sum=0, c_out=1 (carry ripples through all 4 slices).
- Backpressure: hold out_ready=0 for 3 cycles in DONE. Required: sum and c_out stable, in_ready=0, and an in_valid pulse during that window is not accepted.
- Reset: assert rst_n=0 at T0+2 -> out_valid=0, sum=0, in_ready=1. No result is produced; the next operation (1+1) yields 2.
- ADDSUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, c_out=0. a=7, b=5 -> sum=2, c_out=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the sequential chunk adder: FSM states and the chunk-count helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple slice; zero latency, no flow control.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder reusing one CHUNK-bit slice; latency WIDTH/CHUNK cycles.
// Accepts only in IDLE; result held in DONE until out_ready. ADDSUB_EN adds the sub port.
// Option macro: ADDSUB_EN (subtract mode, a - b via inverted b and forced carry-in).
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef ADDSUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("seq_chunk_adder: WIDTH must be an integer multiple of CHUNK");
  end

  state_t            state, state_n;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic [BW-1:0]     base;
  logic [CHUNK-1:0]  a_sl, b_sl, s_sl;
  logic              cy;
  logic              last;

  assign base = BW'(idx * CHUNK);
  assign a_sl = op_a[base +: CHUNK];
  assign b_sl = op_b[base +: CHUNK];
  assign last = (idx == LAST_IDX);

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_sl),
    .b     (b_sl),
    .c_in  (carry),
    .sum   (s_sl),
    .c_out (cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Handshake outputs decode state only, so no input reaches an output combinationally.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = RUN;
      end
      RUN:  if (last) state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a <= a;
          idx  <= '0;
`ifdef ADDSUB_EN
          op_b  <= sub ? ~b : b;
          carry <= sub ? 1'b1 : c_in;
`else
          op_b  <= b;
          carry <= c_in;
`endif
        end
        RUN: begin
          sum[base +: CHUNK] <= s_sl;
          carry              <= cy;
          if (last) c_out <= cy;
          else      idx   <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed vector table, handshake corner cases, random vs model.
module tb_seq_chunk_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int BUDGET = 50;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             c_in;
  logic             sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef ADDSUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [WIDTH-1:0] va, logic [WIDTH-1:0] vb, logic vc,
                              logic vs, logic [WIDTH-1:0] es, logic ec);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.exp_sum = es; v.exp_cout = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, and consume it after `hold` stalled cycles.
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, input logic vs, input int hold,
                        output logic [WIDTH-1:0] rs, output logic rc, output int lat);
    int w = 0;
    while (!in_ready && w < BUDGET) begin tick(); w++; end
    if (w >= BUDGET) check("in_ready_timeout", 64'(in_ready), 64'd1);
    a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom(); b = $urandom(); c_in = 1'($urandom()); sub = 1'($urandom());
    lat = 0;
    while (!out_valid && lat < BUDGET) begin tick(); lat++; end
    for (int i = 0; i < hold; i++) tick();
    rs = sum;
    rc = c_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [WIDTH-1:0] rs;
  logic             rc;
  int               lat;
  logic [WIDTH-1:0] ra, rb;
  logic             rcin, rsub;
  logic [WIDTH:0]   model;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

    vecs.push_back(mk(32'd1024,       32'd4096,       1'b0, 1'b0, 32'd5120,       1'b0));
    vecs.push_back(mk(32'd34343434,   32'd8123659,    1'b0, 1'b0, 32'd42467093,   1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'hFFFF_FFFE,  1'b1));
    vecs.push_back(mk(32'hFFFF_FFFF,  32'h0000_0000,  1'b1, 1'b0, 32'h0000_0000,  1'b1));
    vecs.push_back(mk(32'h0000_0000,  32'h0000_0000,  1'b0, 1'b0, 32'h0000_0000,  1'b0));
    vecs.push_back(mk(32'h00FF_00FF,  32'h0001_0001,  1'b0, 1'b0, 32'h0100_0100,  1'b0));
    vecs.push_back(mk(32'h8000_0000,  32'h8000_0000,  1'b1, 1'b0, 32'h0000_0001,  1'b1));
`ifdef ADDSUB_EN
    vecs.push_back(mk(32'd5,          32'd7,          1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0));
    vecs.push_back(mk(32'd7,          32'd5,          1'b1, 1'b1, 32'd2,          1'b1));
    vecs.push_back(mk(32'd9,          32'd9,          1'b0, 1'b1, 32'd0,          1'b1));
`endif

    #12;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_sum",       64'(sum),       64'd0);
    check("reset_c_out",     64'(c_out),     64'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, rs, rc, lat);
      check($sformatf("vec%0d_sum", i),     64'(rs),  64'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i),    64'(rc),  64'(vecs[i].exp_cout));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NCHUNK));
      check($sformatf("vec%0d_ready_after", i), 64'({in_ready, out_valid}), 64'b10);
    end

    // Backpressure: result held three cycles; an in_valid pulse meanwhile must be ignored.
    a = 32'h1234_5678; b = 32'h1111_1111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_busy_in_run", 64'({busy, in_ready}), 64'b10);
    lat = 0;
    while (!out_valid && lat < BUDGET) begin tick(); lat++; end
    check("bp_latency", 64'(lat), 64'(NCHUNK));
    for (int k = 0; k < 3; k++) begin
      a = 32'h0000_0001; b = 32'h0000_0001; in_valid = (k == 1);
      check($sformatf("bp_hold%0d", k),
            64'({out_valid, in_ready, busy, c_out, sum}), {28'd0, 4'b1010, 32'h2345_6789});
      tick();
    end
    in_valid = 1'b0;
    check("bp_still_done", 64'({out_valid, sum}), {31'd0, 1'b1, 32'h2345_6789});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", 64'({in_ready, out_valid, busy}), 64'b100);
    tick(); tick();
    check("bp_no_phantom_op", 64'({busy, out_valid}), 64'b00);

    // Reset in the middle of RUN discards the operation.
    a = 32'd1000; b = 32'd2000; c_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_state", 64'({out_valid, in_ready, busy, c_out}), 64'b0100);
    check("midrst_sum",   64'(sum), 64'd0);
    #3 rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < NCHUNK + 2; k++) begin tick(); if (out_valid) lat++; end
    check("midrst_no_result", 64'(lat), 64'd0);
    run_op(32'd1, 32'd1, 1'b0, 1'b0, 0, rs, rc, lat);
    check("after_rst_sum", 64'({rc, rs}), 64'd2);

    // Randomised operations against an arithmetic reference.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom(); rb = $urandom(); rcin = 1'($urandom());
      if (n % 5 == 0) rb = ~ra;
`ifdef ADDSUB_EN
      rsub = 1'($urandom());
`else
      rsub = 1'b0;
`endif
      if (rsub) begin
        model[WIDTH-1:0] = ra - rb;
        model[WIDTH]     = (ra >= rb);
      end else begin
        model = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rcin};
      end
      run_op(ra, rb, rcin, rsub, int'($urandom_range(0, 3)), rs, rc, lat);
      check($sformatf("rand%0d_result", n), 64'({rc, rs}), 64'(model));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'(NCHUNK));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
